// File: rtl/ch1_tone_env.sv
`default_nettype none
// ============================================================================
// Module      : ch1_tone_env
// Description : APU square-wave channel 1 output stage. Runs the frequency
//               timer, 8-step duty sequencer, length counter and volume
//               envelope, and produces the 4-bit digital sample plus the
//               active-low channel-running and DAC-power status flags.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk1         in   system clock, all state updates on posedge
//   napu_reset   in   synchronous active-low reset
//   freq_tick    in   1-cycle frequency-timer step enable (1048576 Hz)
//   len_tick     in   1-cycle length-counter step enable (256 Hz)
//   env_tick     in   1-cycle envelope step enable (64 Hz)
//   len_phase    in   1 = next frame-sequencer step clocks length
//   ch1_restart  in   1-cycle trigger pulse
//   ff11_wr      in   NR11 write strobe (loads length from d[5:0])
//   ff14_wr      in   NR14 write strobe
//   d            in   CPU data bus
//   ff11_duty    in   duty select
//   ff12         in   NR12: [7:4] initial volume, [3] direction, [2:0] period
//   ff14_d6      in   length enable
//   acc_d        in   current (swept) frequency
//   sweep_ovf    in   sweep overflow, disables the channel
//   ch1_out      out  digital sample
//   nch1_active  out  0 = channel running
//   nch1_amp_en  out  0 = DAC powered
// Configuration
//   CH1_LEN_QUIRK_EN : when defined, an NR14 write that enables length while
//                      the next frame-sequencer step does not clock length
//                      gives one extra length decrement.
// ============================================================================
module ch1_tone_env #(
   parameter int FREQ_BITS = 11,
   parameter int LEN_BITS  = 6,
   parameter int VOL_BITS  = 4
) (
   input  logic                 clk1,
   input  logic                 napu_reset,
   input  logic                 freq_tick,
   input  logic                 len_tick,
   input  logic                 env_tick,
   input  logic                 len_phase,
   input  logic                 ch1_restart,
   input  logic                 ff11_wr,
   input  logic                 ff14_wr,
   input  logic [7:0]           d,
   input  logic [1:0]           ff11_duty,
   input  logic [7:0]           ff12,
   input  logic                 ff14_d6,
   input  logic [FREQ_BITS-1:0] acc_d,
   input  logic                 sweep_ovf,
   output logic [VOL_BITS-1:0]  ch1_out,
   output logic                 nch1_active,
   output logic                 nch1_amp_en
);

   localparam int                   LEN_W    = LEN_BITS + 1;
   localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0]     LEN_FULL = LEN_W'(1 << LEN_BITS);
   localparam logic [FREQ_BITS-1:0] FCNT_MAX = '1;
   localparam logic [FREQ_BITS-1:0] FCNT_ONE = FREQ_BITS'(1);
   localparam logic [VOL_BITS-1:0]  VOL_MAX  = '1;
   localparam logic [VOL_BITS-1:0]  VOL_ONE  = VOL_BITS'(1);

   // state
   logic [FREQ_BITS-1:0] fcnt;
   logic [2:0]           step;
   logic [LEN_W-1:0]     len;
   logic [VOL_BITS-1:0]  vol;
   logic [2:0]           envdiv;

   // next-state / decode
   logic [FREQ_BITS-1:0] fcnt_nxt;
   logic [2:0]           step_nxt;
   logic [LEN_W-1:0]     len_nxt;
   logic                 len_expire;
   logic [VOL_BITS-1:0]  vol_nxt;
   logic [2:0]           envdiv_nxt;
   logic                 run_nxt;
   logic                 dac_en;
   logic [2:0]           period;
   logic [7:0]           duty_pat;
   logic                 duty_bit;

   assign dac_en = |ff12[7:3];
   assign period = ff12[2:0];

`ifdef CH1_LEN_QUIRK_EN
   logic             quirk_hit;
   logic [LEN_W-1:0] len_base;
   assign quirk_hit = ff14_wr && d[6] && !ff14_d6 && !len_phase && (len != '0);
`else
   logic unused_quirk;
   assign unused_quirk = &{1'b0, len_phase, ff14_wr, d[7:LEN_BITS]};
`endif

   // Duty patterns are written with step 0 in the MSB.
   always_comb begin
      duty_pat = 8'b0000_0001;
      case (ff11_duty)
         2'b00:   duty_pat = 8'b0000_0001;
         2'b01:   duty_pat = 8'b1000_0001;
         2'b10:   duty_pat = 8'b1000_0111;
         default: duty_pat = 8'b0111_1110;
      endcase
      duty_bit = duty_pat[3'd7 - step];
   end

   // Frequency timer and duty step; the trigger reload wins over a tick.
   always_comb begin
      fcnt_nxt = fcnt;
      step_nxt = step;
      if (ch1_restart) begin
         fcnt_nxt = acc_d;
      end else if (freq_tick) begin
         if (fcnt == FCNT_MAX) begin
            fcnt_nxt = acc_d;
            step_nxt = step + 3'd1;
         end else begin
            fcnt_nxt = fcnt + FCNT_ONE;
         end
      end
   end

   // Length counter. A write or trigger in the same cycle as len_tick
   // swallows the tick. Expiry is flagged only on a real 1 -> 0 transition.
   always_comb begin
      len_nxt    = len;
      len_expire = 1'b0;
`ifdef CH1_LEN_QUIRK_EN
      len_base   = len;
`endif
      if (ff11_wr) begin
         len_nxt = LEN_FULL - LEN_W'(d[LEN_BITS-1:0]);
      end else if (ch1_restart) begin
`ifdef CH1_LEN_QUIRK_EN
         if (quirk_hit) begin
            len_base = len - LEN_ONE;
         end
         if (len_base == '0) begin
            len_nxt = quirk_hit ? (LEN_FULL - LEN_ONE) : LEN_FULL;
         end else begin
            len_nxt = len_base;
         end
`else
         len_nxt = (len == '0) ? LEN_FULL : len;
`endif
      end else begin
         if (len_tick && ff14_d6 && (len != '0)) begin
            len_nxt    = len - LEN_ONE;
            len_expire = (len == LEN_ONE);
         end
`ifdef CH1_LEN_QUIRK_EN
         if (quirk_hit && (len_nxt != '0)) begin
            len_nxt = len_nxt - LEN_ONE;
            if ((len_nxt == '0) && !d[7]) begin
               len_expire = 1'b1;
            end
         end
`endif
      end
   end

   // Envelope. envdiv can hold 0 if the period was raised mid-note; treat
   // that like reaching the end of the period so it never wraps.
   always_comb begin
      vol_nxt    = vol;
      envdiv_nxt = envdiv;
      if (ch1_restart) begin
         vol_nxt    = VOL_BITS'(ff12[7:4]);
         envdiv_nxt = period;
      end else if (env_tick && (period != 3'd0)) begin
         if (envdiv <= 3'd1) begin
            envdiv_nxt = period;
            if (ff12[3]) begin
               if (vol != VOL_MAX) vol_nxt = vol + VOL_ONE;
            end else begin
               if (vol != '0) vol_nxt = vol - VOL_ONE;
            end
         end else begin
            envdiv_nxt = envdiv - 3'd1;
         end
      end
   end

   // Channel running flag, highest priority first.
   always_comb begin
      run_nxt = ~nch1_active;
      if (!dac_en) begin
         run_nxt = 1'b0;
      end else if (sweep_ovf) begin
         run_nxt = 1'b0;
      end else if (ch1_restart) begin
         run_nxt = 1'b1;
      end else if (len_expire) begin
         run_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk1) begin
      if (!napu_reset) begin
         fcnt        <= '0;
         step        <= 3'd0;
         len         <= '0;
         vol         <= '0;
         envdiv      <= 3'd0;
         ch1_out     <= '0;
         nch1_active <= 1'b1;
         nch1_amp_en <= 1'b1;
      end else begin
         fcnt        <= fcnt_nxt;
         step        <= step_nxt;
         len         <= len_nxt;
         vol         <= vol_nxt;
         envdiv      <= envdiv_nxt;
         ch1_out     <= (!nch1_active && dac_en && duty_bit) ? vol : '0;
         nch1_active <= ~run_nxt;
         nch1_amp_en <= ~dac_en;
      end
   end

endmodule
`default_nettype wire
